// File: rtl/term_pkg.sv
// term_pkg: shared source ids, state encoding and char width
// for the terminal character arbiter.
package term_pkg;

  localparam int unsigned CHAR_W = 8;

  localparam logic SRC_KEYB   = 1'b0;
  localparam logic SRC_SERIAL = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/term_char_arbiter_if.sv
// term_char_arbiter_if: two character sources and one sink,
// bundled for the arbiter (slave) and its environment (master).
interface term_char_arbiter_if
  import term_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CHAR_W
);

  logic                  i_s0_valid;
  logic [DATA_WIDTH-1:0] i_s0_data;
  logic                  o_s0_ready;
  logic                  i_s1_valid;
  logic [DATA_WIDTH-1:0] i_s1_data;
  logic                  o_s1_ready;
  logic                  o_m_valid;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  o_m_src;
  logic                  i_m_ready;

  modport slave (
    input  i_s0_valid, i_s0_data,
    input  i_s1_valid, i_s1_data,
    input  i_m_ready,
    output o_s0_ready, o_s1_ready,
    output o_m_valid, o_m_data, o_m_src
  );

  modport master (
    output i_s0_valid, i_s0_data,
    output i_s1_valid, i_s1_data,
    output i_m_ready,
    input  o_s0_ready, o_s1_ready,
    input  o_m_valid, o_m_data, o_m_src
  );

endinterface

// File: rtl/rr_grant2.sv
// rr_grant2: combinational two-way grant, round-robin or
// source-0 priority with a burst cap.
module rr_grant2
  import term_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_rr_last,
  input  logic       i_prio_mode,
  input  logic       i_burst_full,
  output logic       o_grant,
  output logic       o_any_valid
);

  assign o_any_valid = |i_valid;

  // A lone requester wins; ties resolve by mode.
  always_comb begin
    o_grant = SRC_KEYB;
    unique case (1'b1)
      (i_valid == 2'b11) && i_prio_mode:
        o_grant = i_burst_full ? SRC_SERIAL : SRC_KEYB;
      (i_valid == 2'b11) && !i_prio_mode:
        o_grant = ~i_rr_last;
      (i_valid == 2'b10):
        o_grant = SRC_SERIAL;
      default:
        o_grant = SRC_KEYB;
    endcase
  end

endmodule

// File: rtl/term_char_arbiter.sv
// term_char_arbiter: shares the terminal sink between the
// keyboard and serial character streams via a 1-entry register.
module term_char_arbiter
  import term_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CHAR_W,
  parameter int unsigned MAX_BURST  = 4
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_prio_mode,
  term_char_arbiter_if.slave  bus
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  state_e                r_state;
  state_e                w_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_src;
  logic                  r_rr_last;
  logic [3:0]            r_burst;

  logic w_grant;
  logic w_any;
  logic w_full;
  logic w_idle;
  logic w_accept;
  logic w_release;

  assign w_full    = (r_burst == LP_MAX);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle && w_any;
  assign w_release = (r_state == ST_HOLD) && bus.i_m_ready;

  rr_grant2 u_grant (
    .i_valid      ({bus.i_s1_valid, bus.i_s0_valid}),
    .i_rr_last    (r_rr_last),
    .i_prio_mode  (i_prio_mode),
    .i_burst_full (w_full),
    .o_grant      (w_grant),
    .o_any_valid  (w_any)
  );

  assign bus.o_s0_ready = w_idle && (w_grant == SRC_KEYB)
                          && bus.i_s0_valid;
  assign bus.o_s1_ready = w_idle && (w_grant == SRC_SERIAL)
                          && bus.i_s1_valid;
  assign bus.o_m_valid  = (r_state == ST_HOLD);
  assign bus.o_m_data   = r_data;
  assign bus.o_m_src    = r_src;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Fill on a grant in IDLE, drain on sink ready in HOLD.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_HOLD;
      ST_HOLD: if (w_release) w_next = ST_IDLE;
    endcase
  end

  // Capture the granted char and update fairness state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= '0;
      r_src     <= SRC_KEYB;
      r_rr_last <= SRC_SERIAL;
      r_burst   <= '0;
    end else if (w_accept) begin
      r_data    <= (w_grant == SRC_SERIAL) ? bus.i_s1_data
                                           : bus.i_s0_data;
      r_src     <= w_grant;
      r_rr_last <= w_grant;
      if (w_grant == SRC_SERIAL) r_burst <= '0;
      else if (!w_full)          r_burst <= r_burst + 4'd1;
    end
  end

endmodule

// File: tb/tb_term_char_arbiter.sv
// tb_term_char_arbiter: directed self-checking bench for the
// terminal character arbiter.
module tb_term_char_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic prio;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  term_char_arbiter_if #(.DATA_WIDTH(8)) bus ();

  term_char_arbiter #(
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_prio_mode (prio),
    .bus         (bus.slave)
  );

  task automatic chk1(input string tag,
                      input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag,
                      input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called at a negedge in IDLE with sources driven, m_ready=1.
  task automatic xfer(input string tag, input logic exp_src,
                      input logic [7:0] exp_data);
    #1;
    chk1({tag, "_rdy0"}, bus.o_s0_ready, !exp_src);
    chk1({tag, "_rdy1"}, bus.o_s1_ready, exp_src);
    tick();
    chk1({tag, "_mvalid"}, bus.o_m_valid, 1'b1);
    chk1({tag, "_src"}, bus.o_m_src, exp_src);
    chk8({tag, "_data"}, bus.o_m_data, exp_data);
    chk1({tag, "_hold_rdy"},
         bus.o_s0_ready | bus.o_s1_ready, 1'b0);
    tick();
    chk1({tag, "_drain"}, bus.o_m_valid, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    prio           = 1'b0;
    bus.i_s0_valid = 1'b0;
    bus.i_s0_data  = 8'h00;
    bus.i_s1_valid = 1'b0;
    bus.i_s1_data  = 8'h00;
    bus.i_m_ready  = 1'b0;
    tick();
    tick();
    chk1("rst_mvalid", bus.o_m_valid, 1'b0);
    chk8("rst_data", bus.o_m_data, 8'h00);
    chk1("rst_src", bus.o_m_src, 1'b0);
    rst = 1'b0;
    tick();

    // single keyboard char
    bus.i_s0_valid = 1'b1;
    bus.i_s0_data  = 8'h41;
    bus.i_m_ready  = 1'b1;
    #1;
    chk1("t1_rdy0", bus.o_s0_ready, 1'b1);
    chk1("t1_rdy1", bus.o_s1_ready, 1'b0);
    tick();
    bus.i_s0_valid = 1'b0;
    #1;
    chk1("t1_mvalid", bus.o_m_valid, 1'b1);
    chk8("t1_data", bus.o_m_data, 8'h41);
    chk1("t1_src", bus.o_m_src, 1'b0);
    chk1("t1_rdy0_off", bus.o_s0_ready, 1'b0);
    tick();
    chk1("t1_drain", bus.o_m_valid, 1'b0);
    chk8("t1_keep", bus.o_m_data, 8'h41);

    // round-robin, both valid
    do_reset();
    bus.i_s0_valid = 1'b1;
    bus.i_s0_data  = 8'h61;
    bus.i_s1_valid = 1'b1;
    bus.i_s1_data  = 8'h31;
    xfer("rr0", 1'b0, 8'h61);
    xfer("rr1", 1'b1, 8'h31);
    xfer("rr2", 1'b0, 8'h61);
    xfer("rr3", 1'b1, 8'h31);
    xfer("rr4", 1'b0, 8'h61);
    xfer("rr5", 1'b1, 8'h31);

    // priority with burst cap 4
    do_reset();
    prio = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) xfer("pr", 1'b1, 8'h31);
      else            xfer("pr", 1'b0, 8'h61);
    end

    // sink stall
    prio           = 1'b0;
    bus.i_s1_valid = 1'b0;
    bus.i_s0_data  = 8'h0D;
    bus.i_m_ready  = 1'b0;
    #1;
    chk1("st_rdy0", bus.o_s0_ready, 1'b1);
    tick();
    bus.i_s0_data = 8'h55;
    bus.i_s1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("st_mvalid", bus.o_m_valid, 1'b1);
      chk8("st_data", bus.o_m_data, 8'h0D);
      chk1("st_src", bus.o_m_src, 1'b0);
      chk1("st_rdy", bus.o_s0_ready | bus.o_s1_ready, 1'b0);
      tick();
    end
    bus.i_s0_valid = 1'b0;
    bus.i_s1_valid = 1'b0;
    bus.i_m_ready  = 1'b1;
    tick();
    chk1("st_drain", bus.o_m_valid, 1'b0);
    tick();
    chk1("st_single", bus.o_m_valid, 1'b0);

    // reset while holding
    bus.i_s0_valid = 1'b1;
    bus.i_s0_data  = 8'h7F;
    bus.i_m_ready  = 1'b0;
    tick();
    bus.i_s0_valid = 1'b0;
    chk1("rh_hold", bus.o_m_valid, 1'b1);
    chk8("rh_data", bus.o_m_data, 8'h7F);
    #2;
    rst = 1'b1;
    #1;
    chk1("rh_async", bus.o_m_valid, 1'b0);
    chk8("rh_clr", bus.o_m_data, 8'h00);
    tick();
    rst = 1'b0;
    bus.i_m_ready  = 1'b1;
    bus.i_s0_valid = 1'b1;
    bus.i_s0_data  = 8'h61;
    bus.i_s1_valid = 1'b1;
    bus.i_s1_data  = 8'h31;
    xfer("rh_tie", 1'b0, 8'h61);

    // serial drops valid while register is full
    bus.i_s1_valid = 1'b0;
    bus.i_s0_data  = 8'h42;
    bus.i_m_ready  = 1'b0;
    tick();
    bus.i_s0_valid = 1'b0;
    bus.i_s1_valid = 1'b1;
    bus.i_s1_data  = 8'h33;
    #1;
    chk1("dr_rdy1", bus.o_s1_ready, 1'b0);
    tick();
    bus.i_s1_valid = 1'b0;
    bus.i_m_ready  = 1'b1;
    tick();
    chk1("dr_drain", bus.o_m_valid, 1'b0);
    chk1("dr_rdy", bus.o_s0_ready | bus.o_s1_ready, 1'b0);
    tick();
    chk1("dr_idle", bus.o_m_valid, 1'b0);
    chk8("dr_data", bus.o_m_data, 8'h42);
    chk1("dr_src", bus.o_m_src, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
